// File: rtl/graphics_pixel_writer.sv
// graphics_pixel_writer
//   Takes a stream of {x, y, color} pixels, buffers them in a small FIFO,
//   computes the frame buffer location in a registered calc stage, and writes
//   each on-screen pixel into a 16-bit-wide Avalon-MM frame buffer (two 8-bit
//   pixels per word, selected with byteenable). Off-screen pixels are dropped
//   and counted.
//
// Ports
//   clk, reset        : clock (rising edge), synchronous active-high reset
//   st_data/valid/ready : pixel stream in, st_data = {x, y, color}
//   mm_address/write/writedata/byteenable : Avalon-MM write master
//   mm_waitrequest    : slave stall for the current write
//   busy              : pixels buffered, in the calc stage, or a write pending
//   clip_count        : saturating count of dropped off-screen pixels
module graphics_pixel_writer #(
  parameter int X_WIDTH     = 10,
  parameter int Y_WIDTH     = 10,
  parameter int COLOR_WIDTH = 8,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int FB_BASE     = 0,
  parameter int ADDR_WIDTH  = 18,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [X_WIDTH+Y_WIDTH+COLOR_WIDTH-1:0] st_data,
  input  logic                                   st_valid,
  output logic                                   st_ready,
  output logic [ADDR_WIDTH-1:0]                  mm_address,
  output logic                                   mm_write,
  output logic [15:0]                            mm_writedata,
  output logic [1:0]                             mm_byteenable,
  input  logic                                   mm_waitrequest,
  output logic                                   busy,
  output logic [15:0]                            clip_count
);

  localparam int DW = X_WIDTH + Y_WIDTH + COLOR_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int IW = ADDR_WIDTH + 1;

  typedef enum logic {IDLE, WRITE} state_e;

  // ---------------------------------------------------------------- FIFO
  logic [DW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          fifo_full, fifo_empty, push, pop;
  logic          calc_advance;

  assign fifo_full  = (count_q == (PW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign st_ready   = !fifo_full;
  assign push       = st_valid && !fifo_full;
  assign pop        = !fifo_empty && calc_advance;

  always_comb begin
    // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // NOTE: storage array has no reset; the pointers and count alone define valid entries.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= st_data;
  end

  // FIFO head decode
  logic [DW-1:0]          head;
  logic [X_WIDTH-1:0]     head_x;
  logic [Y_WIDTH-1:0]     head_y;
  logic [COLOR_WIDTH-1:0] head_color;
  logic [IW-1:0]          idx_d;
  logic                   inb_d;

  assign head       = fifo_mem[rd_ptr_q];
  assign head_x     = head[DW-1 -: X_WIDTH];
  assign head_y     = head[COLOR_WIDTH +: Y_WIDTH];
  assign head_color = head[COLOR_WIDTH-1:0];
  assign idx_d      = IW'(head_y) * IW'(H_RES) + IW'(head_x);
  // One extra bit on each side so the resolution itself is representable.
  assign inb_d      = ({1'b0, head_x} < (X_WIDTH+1)'(H_RES)) &&
                      ({1'b0, head_y} < (Y_WIDTH+1)'(V_RES));

  // ---------------------------------------------------------- calc stage
  logic                   calc_valid_q, calc_inb_q;
  logic [IW-1:0]          calc_idx_q;
  logic [COLOR_WIDTH-1:0] calc_color_q;
  logic                   calc_load_ok, mm_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      calc_valid_q <= 1'b0;
      calc_inb_q   <= 1'b0;
      calc_idx_q   <= '0;
      calc_color_q <= '0;
    end else if (calc_advance) begin
      calc_valid_q <= !fifo_empty;
      calc_inb_q   <= inb_d;
      calc_idx_q   <= idx_d;
      calc_color_q <= head_color;
    end
  end

  assign calc_load_ok = calc_valid_q && calc_inb_q;
  // A clipped pixel is discarded in the same cycle it is replaced.
  assign calc_advance = !calc_valid_q || !calc_inb_q || mm_load;

  // ------------------------------------------------------------ write FSM
  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (calc_load_ok) state_d = WRITE;
      WRITE:   if (!mm_waitrequest && !calc_load_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mm_write = (state_q == WRITE);
    // Load in IDLE, or on the completion cycle of the current write.
    mm_load  = calc_load_ok && ((state_q == IDLE) || !mm_waitrequest);
  end

  // ----------------------------------------------------- MM output regs
  logic [ADDR_WIDTH-1:0] mm_address_q;
  logic [15:0]           mm_writedata_q;
  logic [1:0]            mm_byteenable_q;
  logic [7:0]            lane;

  assign lane = 8'(calc_color_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      mm_address_q    <= '0;
      mm_writedata_q  <= '0;
      mm_byteenable_q <= '0;
    end else if (mm_load) begin
      mm_address_q    <= ADDR_WIDTH'(FB_BASE) + calc_idx_q[ADDR_WIDTH:1];
      mm_writedata_q  <= {lane, lane};
      mm_byteenable_q <= calc_idx_q[0] ? 2'b10 : 2'b01;
    end
  end

  assign mm_address    = mm_address_q;
  assign mm_writedata  = mm_writedata_q;
  assign mm_byteenable = mm_byteenable_q;

  // ------------------------------------------------------- clip counter
  logic [15:0] clip_count_q;
  logic        clip_inc;

  assign clip_inc = calc_valid_q && !calc_inb_q;

  always_ff @(posedge clk) begin
    if (reset)                                 clip_count_q <= '0;
    else if (clip_inc && clip_count_q != 16'hFFFF) clip_count_q <= clip_count_q + 16'd1;
  end

  assign clip_count = clip_count_q;
  assign busy       = !fifo_empty || calc_valid_q || (state_q == WRITE);

endmodule

// File: tb/tb_graphics_pixel_writer.sv
// tb_graphics_pixel_writer
//   Directed bench for graphics_pixel_writer (default parameters). Accepted
//   on-screen pixels push an expected write into a scoreboard queue; each
//   completed Avalon write pops and compares against it.
module tb_graphics_pixel_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [27:0] st_data;
  logic        st_valid;
  logic        st_ready;
  logic [17:0] mm_address;
  logic        mm_write;
  logic [15:0] mm_writedata;
  logic [1:0]  mm_byteenable;
  logic        mm_waitrequest;
  logic        busy;
  logic [15:0] clip_count;

  graphics_pixel_writer dut (
    .clk            (clk),
    .reset          (reset),
    .st_data        (st_data),
    .st_valid       (st_valid),
    .st_ready       (st_ready),
    .mm_address     (mm_address),
    .mm_write       (mm_write),
    .mm_writedata   (mm_writedata),
    .mm_byteenable  (mm_byteenable),
    .mm_waitrequest (mm_waitrequest),
    .busy           (busy),
    .clip_count     (clip_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] addr;
    logic [1:0]  be;
    logic [7:0]  lane;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          n_writes = 0;
  int          first_wr_cyc = 0;
  int          last_wr_cyc  = 0;
  logic        hold_v = 1'b0;
  logic [17:0] hold_addr;
  logic [15:0] hold_data;
  logic [1:0]  hold_be;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  function automatic logic [27:0] pix(input int x, input int y, input int c);
    return {10'(x), 10'(y), 8'(c)};
  endfunction

  // Called in the low phase with inputs already set for the coming edge.
  task automatic cycle(output logic acc);
    exp_t e;
    int   x, y, idx;
    acc = !reset && st_valid && st_ready;
    if (acc) begin
      x = int'(st_data[27:18]);
      y = int'(st_data[17:8]);
      if (x < 640 && y < 480) begin
        idx    = y * 640 + x;
        e.addr = 18'(idx >> 1);
        e.be   = idx[0] ? 2'b10 : 2'b01;
        e.lane = st_data[7:0];
        sb.push_back(e);
      end
    end
    if (!reset && hold_v) begin
      check("stall_write_held", 32'(mm_write), 32'd1);
      check("stall_addr_stable", 32'(mm_address), 32'(hold_addr));
      check("stall_data_stable", 32'(mm_writedata), 32'(hold_data));
      check("stall_be_stable", 32'(mm_byteenable), 32'(hold_be));
    end
    if (!reset && mm_write && !mm_waitrequest) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 32'(mm_write), 32'd0);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(mm_address), 32'(e.addr));
        check("wr_be", 32'(mm_byteenable), 32'(e.be));
        check("wr_lane", 32'(e.be == 2'b01 ? mm_writedata[7:0] : mm_writedata[15:8]), 32'(e.lane));
      end
      if (n_writes == 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      n_writes++;
    end
    hold_v    = !reset && mm_write && mm_waitrequest;
    hold_addr = mm_address;
    hold_data = mm_writedata;
    hold_be   = mm_byteenable;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int   n = 0;
    logic a2;
    while ((sb.size() != 0 || busy) && n < 300) begin
      cycle(a2);
      n++;
    end
    check({tag, "_busy_clear"}, 32'(busy), 32'd0);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin : stim
    logic        a;
    int          k, n;
    logic [27:0] px [8];

    reset = 1'b1; st_valid = 1'b0; st_data = '0; mm_waitrequest = 1'b0;
    @(negedge clk);
    cycle(a);
    cycle(a);
    reset = 1'b0;

    // Reset state
    check("rst_mm_write", 32'(mm_write), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_st_ready", 32'(st_ready), 32'd1);
    check("rst_clip", 32'(clip_count), 32'd0);
    check("rst_addr", 32'(mm_address), 32'd0);
    check("rst_data", 32'(mm_writedata), 32'd0);
    check("rst_be", 32'(mm_byteenable), 32'd0);

    // Single pixel (3,1) color A5: latency and contents
    st_valid = 1'b1; st_data = pix(3, 1, 'hA5);
    cycle(a);
    check("t1_accept", 32'(a), 32'd1);
    st_valid = 1'b0;
    check("t1_lat_n0", 32'(mm_write), 32'd0);
    cycle(a);
    check("t1_lat_n1", 32'(mm_write), 32'd0);
    cycle(a);
    check("t1_lat_n2_write", 32'(mm_write), 32'd1);
    check("t1_addr", 32'(mm_address), 32'd321);
    check("t1_be", 32'(mm_byteenable), 32'h2);
    check("t1_data", 32'(mm_writedata), 32'hA5A5);
    drain("t1");

    // Off-screen pixels are clipped
    n_writes = 0;
    st_valid = 1'b1; st_data = pix(640, 0, 'h11);
    cycle(a);
    st_data = pix(0, 480, 'h22);
    cycle(a);
    st_valid = 1'b0;
    drain("t2");
    check("t2_clip_count", 32'(clip_count), 32'd2);
    check("t2_no_writes", 32'(n_writes), 32'd0);

    // 8 pixels against a 10-cycle stall
    for (int i = 0; i < 8; i++) px[i] = pix(10 + 3 * i, 5 + i, 'h10 + i);
    n_writes = 0;
    mm_waitrequest = 1'b1;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      st_valid = 1'b1; st_data = px[k];
      cycle(a);
      if (a) k++;
    end
    check("t3_accepted_in_stall", 32'(k), 32'd6);
    check("t3_ready_low", 32'(st_ready), 32'd0);
    check("t3_write_held", 32'(mm_write), 32'd1);
    mm_waitrequest = 1'b0;
    n = 0;
    while (k < 8 && n < 50) begin
      st_valid = 1'b1; st_data = px[k];
      cycle(a);
      if (a) k++;
      n++;
    end
    st_valid = 1'b0;
    check("t3_all_accepted", 32'(k), 32'd8);
    drain("t3");
    check("t3_write_count", 32'(n_writes), 32'd8);

    // 100-pixel stream at full rate
    n_writes = 0;
    for (int x = 0; x < 100; x++) begin
      st_valid = 1'b1; st_data = pix(x, 0, x + 1);
      cycle(a);
      if (!a) check("t4_accept", 32'(a), 32'd1);
    end
    st_valid = 1'b0;
    drain("t4");
    check("t4_write_count", 32'(n_writes), 32'd100);
    check("t4_consecutive", 32'(last_wr_cyc - first_wr_cyc), 32'd99);

    // Reset during a stalled write with 3 pixels in the FIFO
    n_writes = 0;
    mm_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      st_valid = 1'b1; st_data = pix(50 + i, 7, 'h40 + i);
      cycle(a);
    end
    st_valid = 1'b0;
    check("t5_busy_before", 32'(busy), 32'd1);
    check("t5_write_before", 32'(mm_write), 32'd1);
    reset = 1'b1;
    cycle(a);
    reset = 1'b0;
    sb.delete();
    check("t5_mm_write", 32'(mm_write), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_st_ready", 32'(st_ready), 32'd1);
    check("t5_clip", 32'(clip_count), 32'd0);
    mm_waitrequest = 1'b0;
    repeat (10) cycle(a);
    check("t5_no_writes", 32'(n_writes), 32'd0);

    // Clip counter saturation
    k = 0; n = 0;
    st_data = pix(700, 0, 0);
    while (k < 65540 && n < 70000) begin
      st_valid = 1'b1;
      cycle(a);
      if (a) k++;
      n++;
    end
    st_valid = 1'b0;
    check("t6_accepted", 32'(k), 32'd65540);
    drain("t6");
    check("t6_clip_saturated", 32'(clip_count), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/graphics_pixel_writer.md
GRAPHICS_PIXEL_WRITER -- requirements
Module: graphics_pixel_writer

Interface
REQ-001 SHALL have parameter X_WIDTH, default 10, width of the pixel x coordinate.
REQ-002 SHALL have parameter Y_WIDTH, default 10, width of the pixel y coordinate.
REQ-003 SHALL have parameter COLOR_WIDTH, default 8, width of the pixel colour.
REQ-004 SHALL have parameters H_RES and V_RES, defaults 640 and 480, the visible frame size in pixels.
REQ-005 SHALL have parameter FB_BASE, default 0, the frame buffer base word address.
REQ-006 SHALL have parameter ADDR_WIDTH, default 18, the Avalon-MM word address width.
REQ-007 SHALL have parameter FIFO_DEPTH, default 4 (power of 2), the input buffer depth.
REQ-008 SHALL have port clk, input, 1 bit: clock; all logic is clocked on the rising edge.
REQ-009 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-010 SHALL have port st_data, input, X_WIDTH+Y_WIDTH+COLOR_WIDTH bits, packed as {x (MSBs), y, color (LSBs)}.
REQ-011 SHALL have port st_valid, input, 1 bit: a pixel is offered on st_data.
REQ-012 SHALL have port st_ready, output, 1 bit: the block can accept a pixel.
REQ-013 SHALL have port mm_address, output, ADDR_WIDTH bits: frame buffer word address.
REQ-014 SHALL have port mm_write, output, 1 bit: write request.
REQ-015 SHALL have port mm_writedata, output, 16 bits: write data.
REQ-016 SHALL have port mm_byteenable, output, 2 bits: write byte lanes.
REQ-017 SHALL have port mm_waitrequest, input, 1 bit: the slave stalls the current write.
REQ-018 SHALL have port busy, output, 1 bit: pixels are buffered or a write is pending.
REQ-019 SHALL have port clip_count, output, 16 bits: number of dropped off-screen pixels.

Function
REQ-020 SHALL accept a pixel when st_valid and st_ready are both high at a rising edge, and st_ready SHALL equal !fifo_full.
REQ-021 SHALL buffer accepted pixels in a FIFO_DEPTH-entry FIFO; a simultaneous push and pop when full SHALL be impossible (ready low), and a simultaneous push and pop when non-empty SHALL keep the occupancy unchanged.
REQ-022 SHALL register, in a calc stage, the popped pixel together with pixel_index = y*H_RES + x (width ADDR_WIDTH+1) and an in-bounds flag (x<H_RES && y<V_RES).
REQ-023 SHALL drop a pixel that fails the in-bounds check (no mm_write) and increment clip_count for it, saturating at 16'hFFFF.
REQ-024 SHALL drive, for an in-bounds pixel, mm_address = FB_BASE + (pixel_index>>1), truncated to ADDR_WIDTH bits.
REQ-025 SHALL drive mm_byteenable = 2'b01 when pixel_index[0]=0 and 2'b10 when pixel_index[0]=1.
REQ-026 SHALL drive mm_writedata = {color,color} zero-extended or truncated to 8 bits per lane; the lanes not enabled carry don't-care data.
REQ-027 SHALL implement write FSM states IDLE and WRITE.
REQ-028 SHALL, in IDLE with an in-bounds pixel in the calc stage, load the MM outputs and move to WRITE.
REQ-029 SHALL, in WRITE, hold mm_write=1 with mm_address, mm_writedata and mm_byteenable stable while mm_waitrequest=1.
REQ-030 SHALL, in WRITE when mm_waitrequest=0, complete the write; on that same cycle it SHALL load the next in-bounds calc-stage pixel and stay in WRITE, otherwise return to IDLE.
REQ-031 SHALL advance the calc stage only when it is empty, holds a clipped pixel, or is being consumed that cycle.
REQ-032 SHALL keep mm_write=0 in IDLE.
REQ-033 SHALL have a latency of exactly 2 cycles: a pixel accepted at edge N with an empty pipeline has mm_write=1 after edge N+2.
REQ-034 SHALL sustain a throughput of 1 pixel per cycle while mm_waitrequest=0.
REQ-035 SHALL assert busy when the FIFO is non-empty, the calc stage is valid, or the FSM is in WRITE.

Reset
REQ-036 SHALL, on reset, empty the FIFO and calc stage, return the FSM to IDLE, clear clip_count, drive mm_write=0, busy=0 and mm_address/mm_writedata/mm_byteenable=0, with st_ready=1 after reset deasserts.
REQ-037 SHALL abandon a write pending under mm_waitrequest when reset is asserted mid-operation, with mm_write low after the reset edge.

Verification
REQ-038 SHALL be tested with a single pixel x=3, y=1, color=8'hA5, FB_BASE=0, waitrequest=0 -> one write: address 321, byteenable 2'b10, writedata 16'hA5A5, exactly 2 cycles after acceptance.
REQ-039 SHALL be tested with pixels (640,0) and (0,480) -> no mm_write, clip_count=2, busy returns to 0.
REQ-040 SHALL be tested with 8 back-to-back pixels and waitrequest held high for 10 cycles -> st_ready low after 4+2 accepted, address/data stable, all 8 writes issued in order once waitrequest drops.
REQ-041 SHALL be tested with 100 consecutive pixels (0..99,0) and waitrequest=0 -> 100 writes on 100 consecutive cycles, byteenable alternating 01/10.
REQ-042 SHALL be tested with reset asserted during a stalled write with 3 pixels buffered -> mm_write=0, busy=0, st_ready=1, clip_count=0 after reset, and no further writes.
REQ-043 SHALL be tested with 65540 off-screen pixels -> clip_count saturates at 16'hFFFF.
